// File: rtl/mem_dump_unit_if.sv
// mem_dump_unit_if: bundles the three buses of the dump engine.
//   command : start, base_addr, count            (to engine)
//             busy, done                         (from engine)
//   memory  : mem_rd_en, mem_addr                (from engine)
//             mem_rd_data                        (to engine, 1-cycle latency)
//   stream  : out_valid, out_addr, out_data      (from engine)
//             out_ready                          (to engine)
// master = the dump engine, slave = the CPU-side / bench environment.
interface mem_dump_unit_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    input  start, base_addr, count, mem_rd_data, out_ready,
    output busy, done, mem_rd_en, mem_addr, out_valid, out_addr, out_data
  );

  modport slave (
    output start, base_addr, count, mem_rd_data, out_ready,
    input  busy, done, mem_rd_en, mem_addr, out_valid, out_addr, out_data
  );
endinterface

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: walks a word-addressed memory from base_addr for count words
// (clamped to DEPTH, addresses wrapping modulo DEPTH) and streams each word with
// its address over a valid/ready interface. One read per word: READ issues the
// strobe, WAIT captures the 1-cycle-latency data, SEND holds it until accepted.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   bus          : mem_dump_unit_if master (command, memory read port, stream)
module mem_dump_unit #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic            clock,
  input  logic            reset,
  mem_dump_unit_if.master bus
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      mem_addr_q <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      mem_addr_q <= mem_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mem_addr_d = mem_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.base_addr;
          rem_d   = (bus.count > DEPTH_C) ? DEPTH_C : bus.count;
          state_d = (bus.count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        mem_addr_d = addr_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        out_data_d = bus.mem_rd_data;
        out_addr_d = addr_q;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
          rem_d   = rem_q - 1'b1;
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          state_d = (rem_q == (ADDR_W+1)'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // mem_addr shows the live counter while reading and otherwise keeps the last
  // address actually presented to the memory.
  assign bus.mem_rd_en = (state_q == S_READ);
  assign bus.mem_addr  = (state_q == S_READ) ? addr_q : mem_addr_q;
  assign bus.out_valid = (state_q == S_SEND);
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_dump_unit.sv
module tb_mem_dump_unit;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_dump_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_dump_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // memory with a synchronous read port
  logic [DW-1:0] mem [D];
  logic [DW-1:0] rd_data_q = '0;
  always @(posedge clock) if (bus.mem_rd_en) rd_data_q <= mem[bus.mem_addr];
  assign bus.mem_rd_data = rd_data_q;

  // event counters, sampled on the active edge
  int rd_cnt   = 0;
  int done_cnt = 0;
  always @(posedge clock) begin
    if (bus.mem_rd_en) rd_cnt++;
    if (bus.done)      done_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      64'(bus.busy), 0);
    chk({tag, "_done"},      64'(bus.done), 0);
    chk({tag, "_valid"},     64'(bus.out_valid), 0);
    chk({tag, "_rden"},      64'(bus.mem_rd_en), 0);
    chk({tag, "_mem_addr"},  64'(bus.mem_addr), 0);
    chk({tag, "_out_addr"},  64'(bus.out_addr), 0);
    chk({tag, "_out_data"},  64'(bus.out_data), 0);
  endtask

  // One dump. Called at a negedge with the unit idle.
  //   stall_word/stall_len : hold out_ready low on that word
  //   poke_word            : pulse start while that word is offered
  //   abort_word           : assert reset while that word is offered
  task automatic run_dump(input int base, input int cnt, input int stall_word,
                          input int stall_len, input int poke_word, input int abort_word);
    int n, lat, rd0, dn0, rd_s;
    int ea [$];
    logic [DW-1:0] ed [$];
    n = (cnt > D) ? D : cnt;
    for (int i = 0; i < n; i++) begin
      ea.push_back((base + i) % D);
      ed.push_back(mem[(base + i) % D]);
    end
    rd0 = rd_cnt;
    dn0 = done_cnt;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.count     = (AW+1)'(cnt);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    chk("busy_rise", 64'(bus.busy), 1);
    if (n == 0) begin
      chk("zero_done",  64'(bus.done), 1);
      chk("zero_rden",  64'(bus.mem_rd_en), 0);
      chk("zero_valid", 64'(bus.out_valid), 0);
    end else begin
      chk("first_rden", 64'(bus.mem_rd_en), 1);
      chk("first_addr", 64'(bus.mem_addr), 64'(base));
    end
    for (int w = 0; w < n; w++) begin
      lat = 1;
      while (!bus.out_valid && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      chk("word_latency", 64'(lat), 3);
      if (!bus.out_valid) return;
      chk("out_addr", 64'(bus.out_addr), 64'(ea[w]));
      chk("out_data", 64'(bus.out_data), 64'(ed[w]));
      if (w == abort_word) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_reset_outputs("abort");
        @(negedge clock);
        chk("abort_idle", 64'(bus.busy), 0);
        chk("abort_no_done", 64'(done_cnt - dn0), 0);
        return;
      end
      if (w == stall_word) begin
        bus.out_ready = 1'b0;
        rd_s = rd_cnt;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clock);
          chk("stall_valid", 64'(bus.out_valid), 1);
          chk("stall_addr",  64'(bus.out_addr), 64'(ea[w]));
          chk("stall_data",  64'(bus.out_data), 64'(ed[w]));
          chk("stall_rden",  64'(bus.mem_rd_en), 0);
        end
        chk("stall_no_reads", 64'(rd_cnt - rd_s), 0);
        bus.out_ready = 1'b1;
      end
      if (w == poke_word) begin
        bus.start     = 1'b1;
        bus.base_addr = AW'($urandom_range(D - 1));
        bus.count     = (AW+1)'(5);
      end
      @(negedge clock);
      bus.start = 1'b0;
    end
    if (n > 0) begin
      chk("done_pulse", 64'(bus.done), 1);
      chk("done_busy",  64'(bus.busy), 1);
    end
    @(negedge clock);
    chk("idle_busy", 64'(bus.busy), 0);
    chk("idle_done", 64'(bus.done), 0);
    chk("read_count", 64'(rd_cnt - rd0), 64'(n));
    chk("done_count", 64'(done_cnt - dn0), 1);
    // nothing restarts afterwards
    repeat (3) @(negedge clock);
    chk("stay_idle", 64'(bus.busy), 0);
    chk("no_extra_done", 64'(done_cnt - dn0), 1);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < D; i++) mem[i] = 32'(i * 4);
    repeat (3) @(negedge clock);
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // full dump, data[i] = i*4
    run_dump(0, 32, -1, 0, -1, -1);

    for (int i = 0; i < D; i++) mem[i] = $urandom;

    // wrap-around
    run_dump(30, 4, -1, 0, -1, -1);
    // backpressure on the second word
    run_dump($urandom_range(D - 1), 3, 1, 5, -1, -1);
    // zero count
    run_dump($urandom_range(D - 1), 0, -1, 0, -1, -1);
    // start pulsed mid-dump is ignored
    run_dump($urandom_range(D - 1), 4, -1, 0, 1, -1);
    // reset while offering word 2 of 8, then a fresh dump
    run_dump($urandom_range(D - 1), 8, -1, 0, -1, 1);
    run_dump($urandom_range(D - 1), $urandom_range(1, D), -1, 0, -1, -1);
    // count clamp
    run_dump(5, 33, -1, 0, -1, -1);
    // random dumps with random stalls
    for (int r = 0; r < 4; r++)
      run_dump($urandom_range(D - 1), $urandom_range(1, D), $urandom_range(0, 3),
               $urandom_range(1, 4), -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Debug read-out engine that walks a word-addressed memory (data memory or register file of the single-cycle CPU) and streams each word, tagged with its address, out over a valid/ready interface. It is the reader counterpart to the bench-side memory preload: after a program runs, it extracts final state in hardware so results can be checked or shipped off-chip without hierarchical peeks. It sits beside the CPU and owns a dedicated synchronous read port on the target memory.

## Interface
- `ADDR_W`, 5: memory address width in words.
- `DATA_W`, 32: memory word width.
- `DEPTH`, 32: number of words. Addresses wrap modulo `DEPTH`.

- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a dump; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first word address; sampled with `start`.
- `count`  in  ADDR_W+1  number of words, 0..DEPTH; sampled with `start`.
- `mem_rd_en`  out  1  read strobe to memory.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rd_data`  in  DATA_W  read data, valid exactly one cycle after the `mem_rd_en` cycle.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_addr`  out  ADDR_W  address of the current output word.
- `out_data`  out  DATA_W  current output word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- IDLE: if `start`=1, latch `base_addr` into the address counter and `count` into the remaining counter. Go to DONE if `count`=0, else to READ. Otherwise stay in IDLE.
- READ: `mem_rd_en`=1, `mem_addr`=address counter. Go to WAIT.
- WAIT: capture `mem_rd_data` into `out_data` and the address counter into `out_addr` at the end of this cycle. Go to SEND.
- SEND: `out_valid`=1. `out_data` and `out_addr` hold stable until the handshake.
  - On `out_valid & out_ready`: decrement remaining, increment the address counter modulo `DEPTH`.
  - If remaining was 1, go to DONE, else go to READ.
  - Without `out_ready`, stay in SEND indefinitely.
- DONE: `done`=1 for this one cycle, then go to IDLE.
- `start` outside IDLE is ignored and is not queued.
- `count` > `DEPTH` is clamped to `DEPTH`.
- Reset values: state IDLE; `mem_rd_en`, `out_valid`, `busy`, `done` = 0; `mem_addr`, `out_addr`, `out_data` = 0.
- Reset mid-dump: the next cycle is IDLE with all outputs at reset values. A pending word is dropped with no `done` pulse.
- Outside READ, `mem_addr` holds its last value and `mem_rd_en`=0.

## Timing
- `start` sampled at edge E0:
  - Cycle after E0: READ.
  - Next cycle: WAIT.
  - Following cycle: SEND with `out_valid`=1. First word appears 3 cycles after E0.
- Steady state with `out_ready`=1: one word per 3 cycles.
- A handshake at edge Ek on the last word gives DONE (`done`=1) in the cycle after Ek, then IDLE, with `busy`=0, one cycle later.
- `count`=0: `done` in the cycle after E0. No `mem_rd_en`, no `out_valid`.
- `busy` rises the cycle after E0 and falls in the IDLE cycle after DONE.
- `out_valid` never deasserts without a handshake, except on reset.
- `out_ready` is ignored when `out_valid`=0.

## Test plan
- Full dump:
  - Setup: memory preloaded with data[i]=i*4; `base_addr`=0, `count`=32, `out_ready`=1.
  - Expected: 32 words, (addr, data) = (0,0), (1,4) … (31,124).
  - First `out_valid` 3 cycles after `start`; `done` the cycle after the 32nd handshake.
- Wrap-around:
  - Setup: `base_addr`=30, `count`=4.
  - Expected: addresses 30, 31, 0, 1 in order, with matching data, then `done`.
- Backpressure:
  - Setup: `count`=3; `out_ready` low for 5 cycles on the second word.
  - Expected: `out_valid`, `out_addr`, `out_data` held constant for those cycles.
  - No extra `mem_rd_en` occurs while stalled; exactly 3 handshakes.
- Zero count and ignored start:
  - `count`=0 gives a `done` pulse the cycle after `start`, with no reads.
  - `start` pulsed while busy mid-dump causes no restart and no second `done`.
- Reset mid-operation:
  - Stimulus: assert `reset` for one cycle while in SEND on word 2 of 8.
  - Expected: the next cycle is IDLE with all outputs at reset values and no `done`.
  - A fresh `start` then dumps correctly from the new `base_addr`.
- Count clamp:
  - Stimulus: `count`=33 (out of range), `base_addr`=5.
  - Expected: exactly 32 words, addresses 5..31 then 0..4.
